// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Drives the program counter into a synchronous instruction memory and registers each returned
// byte, together with the address it came from, towards the control unit.
// A one-entry skid buffer absorbs the single in-flight read when the consumer stalls.
// A jump request from the control unit redirects the PC and flushes all in-flight work.
module instr_fetch #(
  parameter int unsigned PC_W   = 8,
  parameter logic [7:0]  NOP_OP = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,  // first cycle out of reset, nothing issued yet
    RUN  = 2'd1,  // streaming; output reloads every unstalled cycle
    HOLD = 2'd2   // stalled with the in-flight read parked in the skid buffer
  } state_t;

  state_t          state;

  // Fetch side: current PC and a tag for the read whose data arrives this cycle.
  logic [PC_W-1:0] pc_q;
  logic            pend;
  logic [PC_W-1:0] pend_pc;

  // One-entry skid buffer.
  logic            skid_v;
  logic [7:0]      skid_data;
  logic [PC_W-1:0] skid_pc;

  logic            issue;
  logic            skid_load;

  assign imem_addr = pc_q;

  // A new read goes out only when the consumer is taking data and no redirect is pending.
  // Because a stalled cycle never issues, at most one read is in flight when a stall begins,
  // which is why a single skid entry suffices.
  assign issue = (state != BOOT) && !stall && !jmp_en;

  // The in-flight read must be parked when a stall starts while data is arriving.
  assign skid_load = (state == RUN) && stall && pend;

  // Program counter and in-flight tag; a jump redirects the PC and drops the outstanding read.
  always_ff @(posedge clk) begin
    // NOTE: every clocked register here uses non-blocking assignment so all state samples the
    // pre-edge values of its neighbours, regardless of statement order.
    if (rst) begin
      pc_q <= '0;
      pend <= 1'b0;
    end else if (jmp_en) begin
      pc_q <= jmp_addr;
      pend <= 1'b0;
    end else begin
      pend <= issue;
      if (issue) begin
        pc_q <= pc_q + 1'b1;  // wraps from all-ones to zero naturally
      end
    end
  end

  // Payload registers: the address tag of each read and the parked skid entry.
  always_ff @(posedge clk) begin
    // NOTE: these hold data only; their validity is carried by pend and skid_v, which are reset,
    // so the payload itself is deliberately left out of reset.
    if (issue) begin
      pend_pc <= pc_q;
    end
    if (skid_load) begin
      skid_data <= imem_rdata;
      skid_pc   <= pend_pc;
    end
  end

  // Output FSM: loads, holds or parks the returning instruction and drives the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      skid_v     <= 1'b0;
      inst       <= NOP_OP;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (jmp_en) begin
      // Flush wins over stall; inst_pc keeps its last value while the output is empty.
      state      <= RUN;
      skid_v     <= 1'b0;
      inst       <= NOP_OP;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end

        RUN: begin
          if (!stall) begin
            if (skid_v) begin
              inst       <= skid_data;
              inst_pc    <= skid_pc;
              inst_valid <= 1'b1;
              skid_v     <= 1'b0;
            end else if (pend) begin
              inst       <= imem_rdata;
              inst_pc    <= pend_pc;
              inst_valid <= 1'b1;
            end else begin
              inst       <= NOP_OP;
              inst_valid <= 1'b0;
            end
          end else if (pend) begin
            // Output holds; the read arriving now is parked so it is not lost.
            skid_v <= 1'b1;
            state  <= HOLD;
          end
        end

        HOLD: begin
          if (!stall) begin
            inst       <= skid_data;
            inst_pc    <= skid_pc;
            inst_valid <= 1'b1;
            skid_v     <= 1'b0;
            state      <= RUN;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch.
// Directed scenarios with hand-derived cycle-exact expectations, followed by a randomized run
// checked against a transaction-level model: delivery order (no loss, no duplicates, jump and
// reset restart points), data integrity against the memory image, hold behaviour under stall,
// flush behaviour on jump, and a throughput/latency bound after three clean cycles.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       jmp_en;
  logic [7:0] jmp_addr;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [7:0] inst;
  logic [7:0] inst_pc;
  logic       inst_valid;

  logic [7:0] mem [256];

  int checks   = 0;
  int failures = 0;

  // Model state for the randomized phase.
  logic [7:0] exp_next;
  int         clean_run;

  instr_fetch #(
    .PC_W  (8),
    .NOP_OP(8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data for an address appears the cycle after it.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] i,
                            input logic [7:0] p, input logic [7:0] a);
    check({tag, "_valid"}, inst_valid, v);
    check({tag, "_inst"}, inst, i);
    check({tag, "_pc"}, inst_pc, p);
    check({tag, "_addr"}, imem_addr, a);
  endtask

  // Release reset (already applied) and follow the cold-start stream for n edges.
  task automatic boot_seq(input string tag, input int n);
    rst   = 1'b0;
    stall = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k >= 3)
        expect_out(tag, 1'b1, 8'(8'h10 + k - 3), 8'(k - 3), 8'(k - 1));
      else
        expect_out(tag, 1'b0, 8'h00, 8'h00, (k >= 2) ? 8'(k - 1) : 8'h00);
    end
  endtask

  // One randomized cycle checked against the transaction-level model.
  task automatic rand_step();
    logic       r, j, s;
    logic [7:0] ja;
    logic       p_v;
    logic [7:0] p_i, p_pc, p_a;
    r  = ($urandom_range(63) == 0);
    j  = ($urandom_range(11) == 0);
    s  = ($urandom_range(2) == 0);
    ja = 8'($urandom);
    rst = r; jmp_en = j; stall = s; jmp_addr = ja;
    p_v = inst_valid; p_i = inst; p_pc = inst_pc; p_a = imem_addr;
    tick();
    if (r) begin
      expect_out("rnd_rst", 1'b0, 8'h00, 8'h00, 8'h00);
      exp_next  = 8'h00;
      clean_run = 0;
    end else begin
      // A valid instruction presented on an unstalled edge is consumed exactly once, in order.
      if (p_v && !s) begin
        check("rnd_order", p_pc, exp_next);
        exp_next = exp_next + 8'h01;
      end
      if (j) begin
        check("rnd_jmp_valid", inst_valid, 1'b0);
        check("rnd_jmp_addr", imem_addr, ja);
        exp_next  = ja;
        clean_run = 0;
      end else if (s) begin
        check("rnd_stall_inst", inst, p_i);
        check("rnd_stall_pc", inst_pc, p_pc);
        check("rnd_stall_valid", inst_valid, p_v);
        check("rnd_stall_addr", imem_addr, p_a);
        clean_run = 0;
      end else begin
        clean_run++;
        if (clean_run >= 3) check("rnd_throughput", inst_valid, 1'b1);
      end
      if (inst_valid) begin
        check("rnd_data", inst, mem[inst_pc]);
      end else begin
        check("rnd_nop", inst, 8'h00);
        check("rnd_pc_hold", inst_pc, p_pc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
    rst = 1'b1; stall = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00;

    // Test 1: reset for two cycles, then cold start.
    tick();
    tick();
    expect_out("t1_reset", 1'b0, 8'h00, 8'h00, 8'h00);
    boot_seq("t1", 7);  // ends with inst=14, inst_pc=4, imem_addr=6

    // Test 2: three stalled cycles while inst=14, then the stream resumes without gaps.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("t2_stall", 1'b1, 8'h14, 8'h04, 8'h06);
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("t2_resume", 1'b1, 8'(8'h15 + k), 8'(5 + k), 8'(7 + k));
    end

    // Test 3: jump to 40 while inst=12; 13 must never be delivered.
    rst = 1'b1;
    tick();
    expect_out("t3_reset", 1'b0, 8'h00, 8'h00, 8'h00);
    boot_seq("t3_boot", 5);  // inst=12
    jmp_en = 1'b1; jmp_addr = 8'h40;
    tick();
    expect_out("t3_flush", 1'b0, 8'h00, 8'h02, 8'h40);
    jmp_en = 1'b0;
    tick();
    expect_out("t3_issue", 1'b0, 8'h00, 8'h02, 8'h41);
    tick();
    expect_out("t3_target", 1'b1, 8'h50, 8'h40, 8'h42);
    tick();
    expect_out("t3_next", 1'b1, 8'h51, 8'h41, 8'h43);

    // Test 4: fill the skid, then jump with stall held; skid must be discarded.
    stall = 1'b1;
    tick();
    expect_out("t4_hold", 1'b1, 8'h51, 8'h41, 8'h43);
    jmp_en = 1'b1; jmp_addr = 8'h80;
    tick();
    expect_out("t4_flush", 1'b0, 8'h00, 8'h41, 8'h80);
    jmp_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      expect_out("t4_stalled", 1'b0, 8'h00, 8'h41, 8'h80);
    end
    stall = 1'b0;
    tick();
    expect_out("t4_issue", 1'b0, 8'h00, 8'h41, 8'h81);
    tick();
    expect_out("t4_target", 1'b1, 8'h90, 8'h80, 8'h82);
    tick();
    expect_out("t4_next", 1'b1, 8'h91, 8'h81, 8'h83);

    // Test 5: jump to FE and run across the address wrap.
    jmp_en = 1'b1; jmp_addr = 8'hFE;
    tick();
    expect_out("t5_flush", 1'b0, 8'h00, 8'h81, 8'hFE);
    jmp_en = 1'b0;
    tick();
    expect_out("t5_issue", 1'b0, 8'h00, 8'h81, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_out("t5_wrap", 1'b1, 8'(8'h0E + k), 8'(8'hFE + k), 8'(k));
    end

    // Test 6: reset mid-stall with the skid full, then an identical cold start.
    stall = 1'b1;
    tick();
    expect_out("t6_hold", 1'b1, 8'h11, 8'h01, 8'h03);
    rst = 1'b1;
    tick();
    expect_out("t6_reset", 1'b0, 8'h00, 8'h00, 8'h00);
    boot_seq("t6_boot", 5);

    // Randomized phase with a random memory image.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1; stall = 1'b0; jmp_en = 1'b0;
    tick();
    exp_next  = 8'h00;
    clean_run = 0;
    for (int n = 0; n < 3000; n++) rand_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
